// File: rtl/lcd_refresh_sequencer.sv
// HD44780 16x2 sequencer: power-on init, then endless refresh of 32 character cells.
// Every phase is timed by one 21-bit down-counter. A wait parameter of 0 behaves as 1 cycle.
//
// state    | meaning
// ST_PWR   | power-on wait before the first command
// ST_INIT0 | function set 8'h38
// ST_INIT1 | display on, no cursor 8'h0C
// ST_INIT2 | clear display 8'h01 (long hold)
// ST_INIT3 | entry mode increment 8'h06
// ST_ADDR1 | DDRAM address line 1 (8'h80)
// ST_LINE1 | data writes for cells 0..15
// ST_ADDR2 | DDRAM address line 2 (8'hC0)
// ST_LINE2 | data writes for cells 16..31
module lcd_refresh_sequencer #(
  parameter int unsigned PWR_WAIT  = 1000000,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 16,
  parameter int unsigned CMD_WAIT  = 2500,
  parameter int unsigned CLR_WAIT  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [7:0] lcd_char,
  output logic [4:0] lcd_index,
  output logic       frame_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  inout  wire  [7:0] LCD_DATA
);

  typedef enum logic [3:0] {
    ST_PWR,
    ST_INIT0,
    ST_INIT1,
    ST_INIT2,
    ST_INIT3,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_t;

  // Timer load values are count-1 so the terminal count (0) ends the phase.
  localparam logic [20:0] PWR_LD   = (PWR_WAIT  == 0) ? 21'd0 : 21'(PWR_WAIT  - 1);
  localparam logic [20:0] SETUP_LD = (SETUP_CYC == 0) ? 21'd0 : 21'(SETUP_CYC - 1);
  localparam logic [20:0] EN_LD    = (EN_CYC    == 0) ? 21'd0 : 21'(EN_CYC    - 1);
  localparam logic [20:0] CMD_LD   = (CMD_WAIT  == 0) ? 21'd0 : 21'(CMD_WAIT  - 1);
  localparam logic [20:0] CLR_LD   = (CLR_WAIT  == 0) ? 21'd0 : 21'(CLR_WAIT  - 1);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [20:0] timer_q, timer_d;
  logic [7:0]  data_q;
  logic        rs_q;
  logic        en_q;
  logic [4:0]  idx_q;
  logic        frame_done_q;

  logic        tc;
  logic        is_clr;
  logic        load_byte;
  logic [7:0]  byte_d;
  logic        rs_d;
  logic        idx_adv;
  logic        frame_end;

  assign tc     = (timer_q == 21'd0);
  assign is_clr = !rs_q && (data_q == 8'h01);

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_PWR;
      phase_q <= PH_SETUP;
      timer_q <= PWR_LD;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    timer_d   = timer_q;
    load_byte = 1'b0;
    if (!tc) begin
      timer_d = timer_q - 21'd1;
    end else if (state_q == ST_PWR) begin
      state_d   = ST_INIT0;
      phase_d   = PH_SETUP;
      timer_d   = SETUP_LD;
      load_byte = 1'b1;
    end else begin
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_STROBE;
          timer_d = EN_LD;
        end
        PH_STROBE: begin
          phase_d = PH_HOLD;
          timer_d = is_clr ? CLR_LD : CMD_LD;
        end
        default: begin
          phase_d   = PH_SETUP;
          timer_d   = SETUP_LD;
          load_byte = 1'b1;
          case (state_q)
            ST_INIT0: state_d = ST_INIT1;
            ST_INIT1: state_d = ST_INIT2;
            ST_INIT2: state_d = ST_INIT3;
            ST_INIT3: state_d = ST_ADDR1;
            ST_ADDR1: state_d = ST_LINE1;
            ST_LINE1: state_d = (idx_q == 5'd16) ? ST_ADDR2 : ST_LINE1;
            ST_ADDR2: state_d = ST_LINE2;
            ST_LINE2: state_d = (idx_q == 5'd0) ? ST_ADDR1 : ST_LINE2;
            default:  state_d = ST_PWR;
          endcase
        end
      endcase
    end
  end

  // Byte for the write that starts next cycle; data cells take the upstream character.
  always_comb begin
    byte_d = 8'h00;
    rs_d   = 1'b0;
    case (state_d)
      ST_INIT0: byte_d = 8'h38;
      ST_INIT1: byte_d = 8'h0C;
      ST_INIT2: byte_d = 8'h01;
      ST_INIT3: byte_d = 8'h06;
      ST_ADDR1: byte_d = 8'h80;
      ST_ADDR2: byte_d = 8'hC0;
      ST_LINE1, ST_LINE2: begin
        byte_d = lcd_char;
        rs_d   = 1'b1;
      end
      default: byte_d = 8'h00;
    endcase
  end

  // Index moves as the last HOLD cycle of a data write begins, one cycle ahead of the next latch.
  assign idx_adv = rs_q && (state_q != ST_PWR) && (phase_d == PH_HOLD) && (timer_d == 21'd0) &&
                   !((phase_q == PH_HOLD) && tc);

  // In LINE2 the index reads 0 only during the final HOLD cycle of cell 31.
  assign frame_end = (state_q == ST_LINE2) && (phase_q == PH_HOLD) && tc && (idx_q == 5'd0);

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      idx_q        <= 5'd0;
      frame_done_q <= 1'b0;
    end else begin
      if (load_byte) begin
        data_q <= byte_d;
        rs_q   <= rs_d;
      end
      en_q         <= (phase_d == PH_STROBE);
      frame_done_q <= frame_end;
      if (idx_adv) begin
        idx_q <= idx_q + 5'd1;
      end
    end
  end

  assign lcd_index  = idx_q;
  assign frame_done = frame_done_q;
  assign LCD_EN     = en_q;
  assign LCD_RS     = rs_q;
  assign LCD_DATA   = data_q;
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = 1'b1;
  assign LCD_RW     = 1'b0;

endmodule
